// File: rtl/map_ctrl.sv
// map_ctrl: level-map controller for a single elevator platform and a set of
// collectible gems that open an exit door.
//
// Build option: define MAP_CTRL_AUTORETURN_EN to make the elevator follow the
// button (return up on release, reverse mid-travel). Without it the elevator
// descends once and parks at the bottom until level_restart or reset.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   en            global enable; when low all state holds (level_restart still acts)
//   frame_tick    one-cycle pulse per video frame, paces elevator motion
//   vga_h, vga_v  full-res pixel position (halved internally)
//   button_press  player standing on the elevator button (level)
//   gem_touch     per-gem player contact (level)
//   level_restart synchronous restart pulse, highest priority
//   plat_off      elevator downward offset in half-res pixels
//   plat_state    elevator state: 0 TOP, 1 DOWN, 2 BOTTOM, 3 UP
//   plat_hit      combinational: current pixel lies inside the elevator
//   gem_taken     latched gem collection flags
//   gem_count     number of gems taken
//   door_open     all gems collected (sticky)
//   done_pulse    one-cycle pulse when the door opens
module map_ctrl #(
  parameter int unsigned NUM_GEMS    = 4,
  parameter int unsigned PLAT_TRAVEL = 40,
  parameter int unsigned STEP_DIV    = 2,
  parameter int unsigned PLAT_H0     = 90,
  parameter int unsigned PLAT_V0     = 139,
  parameter int unsigned PLAT_W      = 40,
  parameter int unsigned PLAT_HT     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                frame_tick,
  input  logic [9:0]          vga_h,
  input  logic [9:0]          vga_v,
  input  logic                button_press,
  input  logic [NUM_GEMS-1:0] gem_touch,
  input  logic                level_restart,
  output logic [9:0]          plat_off,
  output logic [1:0]          plat_state,
  output logic                plat_hit,
  output logic [NUM_GEMS-1:0] gem_taken,
  output logic [3:0]          gem_count,
  output logic                door_open,
  output logic                done_pulse
);

  localparam int unsigned OFF_W = 10;
  localparam int unsigned DIV_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned PIX_W = 11;

  typedef enum logic [1:0] {
    ST_TOP    = 2'd0,
    ST_DOWN   = 2'd1,
    ST_BOTTOM = 2'd2,
    ST_UP     = 2'd3
  } plat_st_e;

  plat_st_e               state_q, state_d;
  logic [OFF_W-1:0]       off_q, off_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [NUM_GEMS-1:0]    gem_taken_q, gem_taken_d;
  logic [CNT_W-1:0]       gem_count_q, gem_count_d;
  logic                   door_open_q, door_open_d;
  logic                   done_pulse_q, done_pulse_d;
  logic                   step_due;
  logic                   all_gems;

  // Number of set bits in a gem vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_GEMS-1:0] vec);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < NUM_GEMS; i++) begin
      cnt = cnt + CNT_W'(vec[i]);
    end
    return cnt;
  endfunction

  // Elevator next-state, offset and step divider.
  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    div_d    = div_q;
    step_due = 1'b0;
    if (level_restart) begin
      state_d = ST_TOP;
      off_d   = '0;
      div_d   = '0;
    end else if (en) begin
      // The divider wraps on the tick that produces a 1-pixel step.
      step_due = frame_tick && (div_q == DIV_W'(STEP_DIV - 1));
      case (state_q)
        ST_TOP: begin
          if (button_press) state_d = ST_DOWN;
        end
        ST_DOWN: begin
          if (off_q >= OFF_W'(PLAT_TRAVEL)) begin
            // Entered already at the bottom (reversal at full travel).
            state_d = ST_BOTTOM;
          end else if (frame_tick) begin
            if (step_due) begin
              div_d = '0;
              off_d = off_q + OFF_W'(1);
              if (off_q == OFF_W'(PLAT_TRAVEL - 1)) state_d = ST_BOTTOM;
            end else begin
              div_d = div_q + DIV_W'(1);
            end
          end
`ifdef MAP_CTRL_AUTORETURN_EN
          // Releasing the button reverses without taking a step this cycle.
          if (!button_press) begin
            state_d = ST_UP;
            off_d   = off_q;
          end
`endif
        end
        ST_BOTTOM: begin
`ifdef MAP_CTRL_AUTORETURN_EN
          if (!button_press) state_d = ST_UP;
`endif
        end
        ST_UP: begin
`ifdef MAP_CTRL_AUTORETURN_EN
          if (off_q == '0) begin
            state_d = ST_TOP;
          end else if (frame_tick) begin
            if (step_due) begin
              div_d = '0;
              off_d = off_q - OFF_W'(1);
              if (off_q == OFF_W'(1)) state_d = ST_TOP;
            end else begin
              div_d = div_q + DIV_W'(1);
            end
          end
          if (button_press) begin
            state_d = ST_DOWN;
            off_d   = off_q;
          end
`else
          // Unreachable in this build; recover to a safe parked state.
          state_d = ST_TOP;
          off_d   = '0;
`endif
        end
        default: state_d = ST_TOP;
      endcase
      if (state_d != state_q) div_d = '0;
    end
  end

  // Gem collection, door and completion pulse.
  always_comb begin
    gem_taken_d  = gem_taken_q;
    gem_count_d  = gem_count_q;
    door_open_d  = door_open_q;
    done_pulse_d = 1'b0;
    all_gems     = (gem_count_q == CNT_W'(NUM_GEMS));
    if (level_restart) begin
      gem_taken_d = '0;
      gem_count_d = '0;
      door_open_d = 1'b0;
    end else if (en) begin
      gem_taken_d  = gem_taken_q | gem_touch;
      gem_count_d  = popcount(gem_taken_d);
      door_open_d  = door_open_q | all_gems;
      done_pulse_d = all_gems && !door_open_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_TOP;
      off_q        <= '0;
      div_q        <= '0;
      gem_taken_q  <= '0;
      gem_count_q  <= '0;
      door_open_q  <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      div_q        <= div_d;
      gem_taken_q  <= gem_taken_d;
      gem_count_q  <= gem_count_d;
      door_open_q  <= door_open_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  // Elevator rectangle hit test in half-res coordinates.
  logic [PIX_W-1:0] h_px, v_px, v_top;
  always_comb begin
    h_px  = PIX_W'(vga_h >> 1);
    v_px  = PIX_W'(vga_v >> 1);
    v_top = PIX_W'(PLAT_V0) + PIX_W'(off_q);
    plat_hit = (h_px >= PIX_W'(PLAT_H0)) && (h_px < PIX_W'(PLAT_H0 + PLAT_W)) &&
               (v_px >= v_top) && (v_px < v_top + PIX_W'(PLAT_HT));
  end

  assign plat_off   = off_q;
  assign plat_state = state_q;
  assign gem_taken  = gem_taken_q;
  assign gem_count  = gem_count_q;
  assign door_open  = door_open_q;
  assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_map_ctrl.sv
// Directed testbench for map_ctrl with default parameters.
module tb_map_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] vga_h = '0;
  logic [9:0] vga_v = '0;
  logic       button_press = 1'b0;
  logic [3:0] gem_touch = '0;
  logic       level_restart = 1'b0;
  logic [9:0] plat_off;
  logic [1:0] plat_state;
  logic       plat_hit;
  logic [3:0] gem_taken;
  logic [3:0] gem_count;
  logic       door_open;
  logic       done_pulse;

  int passed = 0;
  int total  = 0;

  map_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .frame_tick(frame_tick),
    .vga_h(vga_h), .vga_v(vga_v), .button_press(button_press),
    .gem_touch(gem_touch), .level_restart(level_restart),
    .plat_off(plat_off), .plat_state(plat_state), .plat_hit(plat_hit),
    .gem_taken(gem_taken), .gem_count(gem_count),
    .door_open(door_open), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  task automatic restart();
    level_restart = 1'b1;
    tick();
    level_restart = 1'b0;
  endtask

  task automatic test_reset();
    logic [21:0] outs;
    #1 rst = 1'b0;
    #2;
    outs = {plat_off, plat_state, gem_taken, gem_count, door_open, done_pulse};
    total++;
    if (outs !== 22'd0) $display("FAIL reset_outputs: got %h expected 0", outs);
    else passed++;
    #14 rst = 1'b1;
    tick();
    outs = {plat_off, plat_state, gem_taken, gem_count, door_open, done_pulse};
    total++;
    if (outs !== 22'd0) $display("FAIL idle_after_reset: got %h expected 0", outs);
    else passed++;
    // Offset 0: rows 139..146 hit.
    vga_h = 10'd200; vga_v = 10'd278; #1;
    total++;
    if (plat_hit !== 1'b1) $display("FAIL hit_top_row: got %b expected 1", plat_hit);
    else passed++;
    vga_v = 10'd276; #1;
    total++;
    if (plat_hit !== 1'b0) $display("FAIL hit_above_top: got %b expected 0", plat_hit);
    else passed++;
  endtask

  task automatic test_descend();
    int exp_off;
    int exp_st;
    button_press = 1'b1;
    tick();
    total++;
    if (plat_state !== 2'd1 || plat_off !== 10'd0)
      $display("FAIL press_to_down: got state %0d off %0d expected 1 0", plat_state, plat_off);
    else passed++;
    for (int k = 1; k <= 80; k++) begin
      frame();
      exp_off = k / 2;
      exp_st  = (exp_off == 40) ? 2 : 1;
      total++;
      if (plat_off !== 10'(exp_off) || plat_state !== 2'(exp_st))
        $display("FAIL descend_k%0d: got off %0d state %0d expected %0d %0d",
                 k, plat_off, plat_state, exp_off, exp_st);
      else passed++;
    end
    for (int k = 0; k < 4; k++) frame();
    total++;
    if (plat_off !== 10'd40 || plat_state !== 2'd2)
      $display("FAIL no_overrun: got off %0d state %0d expected 40 2", plat_off, plat_state);
    else passed++;
    // Offset 40: rows 179..186, columns 90..129.
    vga_h = 10'd200; vga_v = 10'd358; #1;
    total++;
    if (plat_hit !== 1'b1) $display("FAIL hit_v179: got %b expected 1", plat_hit); else passed++;
    vga_v = 10'd357; #1;
    total++;
    if (plat_hit !== 1'b0) $display("FAIL hit_v178: got %b expected 0", plat_hit); else passed++;
    vga_v = 10'd373; #1;
    total++;
    if (plat_hit !== 1'b1) $display("FAIL hit_v186: got %b expected 1", plat_hit); else passed++;
    vga_v = 10'd374; #1;
    total++;
    if (plat_hit !== 1'b0) $display("FAIL hit_v187: got %b expected 0", plat_hit); else passed++;
    vga_v = 10'd360; vga_h = 10'd180; #1;
    total++;
    if (plat_hit !== 1'b1) $display("FAIL hit_h90: got %b expected 1", plat_hit); else passed++;
    vga_h = 10'd179; #1;
    total++;
    if (plat_hit !== 1'b0) $display("FAIL hit_h89: got %b expected 0", plat_hit); else passed++;
    vga_h = 10'd259; #1;
    total++;
    if (plat_hit !== 1'b1) $display("FAIL hit_h129: got %b expected 1", plat_hit); else passed++;
    vga_h = 10'd260; #1;
    total++;
    if (plat_hit !== 1'b0) $display("FAIL hit_h130: got %b expected 0", plat_hit); else passed++;
  endtask

`ifdef MAP_CTRL_AUTORETURN_EN
  task automatic test_autoreturn();
    button_press = 1'b0;
    restart();
    button_press = 1'b1;
    tick();
    for (int k = 0; k < 30; k++) frame();
    total++;
    if (plat_off !== 10'd15 || plat_state !== 2'd1)
      $display("FAIL ar_at15: got off %0d state %0d expected 15 1", plat_off, plat_state);
    else passed++;
    button_press = 1'b0;
    tick();
    total++;
    if (plat_off !== 10'd15 || plat_state !== 2'd3)
      $display("FAIL ar_reverse: got off %0d state %0d expected 15 3", plat_off, plat_state);
    else passed++;
    for (int k = 0; k < 29; k++) frame();
    total++;
    if (plat_off !== 10'd1 || plat_state !== 2'd3)
      $display("FAIL ar_29ticks: got off %0d state %0d expected 1 3", plat_off, plat_state);
    else passed++;
    frame();
    total++;
    if (plat_off !== 10'd0 || plat_state !== 2'd0)
      $display("FAIL ar_30ticks: got off %0d state %0d expected 0 0", plat_off, plat_state);
    else passed++;
  endtask
`else
  task automatic test_bottom_terminal();
    button_press = 1'b0;
    for (int k = 0; k < 6; k++) frame();
    total++;
    if (plat_off !== 10'd40 || plat_state !== 2'd2)
      $display("FAIL bottom_terminal: got off %0d state %0d expected 40 2", plat_off, plat_state);
    else passed++;
  endtask
`endif

  task automatic test_restart_priority();
    button_press = 1'b0;
    restart();
    gem_touch = 4'b0001;
    button_press = 1'b1;
    tick();
    total++;
    if (plat_state !== 2'd1 || gem_taken !== 4'b0001)
      $display("FAIL pre_restart: got state %0d gems %b expected 1 0001", plat_state, gem_taken);
    else passed++;
    level_restart = 1'b1;
    gem_touch = 4'b1110;
    frame_tick = 1'b1;
    tick();
    level_restart = 1'b0;
    gem_touch = 4'b0000;
    frame_tick = 1'b0;
    button_press = 1'b0;
    total++;
    if ({plat_off, plat_state, gem_taken, gem_count, door_open, done_pulse} !== 22'd0)
      $display("FAIL restart_clears: got off %0d state %0d gems %b count %0d expected all 0",
               plat_off, plat_state, gem_taken, gem_count);
    else passed++;
    tick();
    total++;
    if (plat_state !== 2'd0 || gem_taken !== 4'b0000)
      $display("FAIL restart_stays: got state %0d gems %b expected 0 0000", plat_state, gem_taken);
    else passed++;
  endtask

  task automatic test_gems();
    int pulses;
    restart();
    gem_touch = 4'b0101;
    tick();
    gem_touch = 4'b0000;
    total++;
    if (gem_taken !== 4'b0101 || gem_count !== 4'd2 || door_open !== 1'b0)
      $display("FAIL gems_two: got %b count %0d door %b expected 0101 2 0", gem_taken, gem_count, door_open);
    else passed++;
    tick();
    gem_touch = 4'b0010;
    tick();
    gem_touch = 4'b0000;
    total++;
    if (gem_count !== 4'd3) $display("FAIL gems_three: got %0d expected 3", gem_count);
    else passed++;
    gem_touch = 4'b1000;
    tick();
    gem_touch = 4'b0000;
    total++;
    if (gem_taken !== 4'b1111 || gem_count !== 4'd4 || door_open !== 1'b0 || done_pulse !== 1'b0)
      $display("FAIL gems_four: got %b count %0d door %b done %b expected 1111 4 0 0",
               gem_taken, gem_count, door_open, done_pulse);
    else passed++;
    tick();
    total++;
    if (door_open !== 1'b1 || done_pulse !== 1'b1)
      $display("FAIL door_opens: got door %b done %b expected 1 1", door_open, done_pulse);
    else passed++;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done_pulse === 1'b1) pulses++;
    end
    total++;
    if (door_open !== 1'b1 || pulses != 0)
      $display("FAIL done_single: got door %b extra pulses %0d expected 1 0", door_open, pulses);
    else passed++;
  endtask

  task automatic test_hold();
    restart();
    gem_touch = 4'b0010;
    for (int k = 0; k < 100; k++) begin
      tick();
      total++;
      if (gem_count !== 4'd1) $display("FAIL hold_c%0d: got %0d expected 1", k, gem_count);
      else passed++;
    end
    gem_touch = 4'b0000;
    tick();
    total++;
    if (gem_taken !== 4'b0010) $display("FAIL hold_taken: got %b expected 0010", gem_taken);
    else passed++;
  endtask

  task automatic test_en_gate();
    restart();
    en = 1'b0;
    button_press = 1'b1;
    gem_touch = 4'b1111;
    for (int k = 0; k < 6; k++) frame();
    total++;
    if (plat_state !== 2'd0 || plat_off !== 10'd0 || gem_taken !== 4'b0000 || gem_count !== 4'd0)
      $display("FAIL en_low_ignores: got state %0d off %0d gems %b count %0d expected 0 0 0000 0",
               plat_state, plat_off, gem_taken, gem_count);
    else passed++;
    en = 1'b1;
    button_press = 1'b0;
    gem_touch = 4'b0011;
    tick();
    gem_touch = 4'b0000;
    en = 1'b0;
    restart();
    total++;
    if (gem_taken !== 4'b0000 || gem_count !== 4'd0)
      $display("FAIL en_low_restart: got gems %b count %0d expected 0000 0", gem_taken, gem_count);
    else passed++;
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    restart();
    button_press = 1'b1;
    tick();
    for (int k = 0; k < 40; k++) frame();
    total++;
    if (plat_off !== 10'd20) $display("FAIL pre_async_off: got %0d expected 20", plat_off);
    else passed++;
    #2;
    rst = 1'b0;
    button_press = 1'b0;
    #1;
    total++;
    if (plat_off !== 10'd0 || plat_state !== 2'd0 || gem_count !== 4'd0 || door_open !== 1'b0)
      $display("FAIL async_reset: got off %0d state %0d expected 0 0", plat_off, plat_state);
    else passed++;
    #2 rst = 1'b1;
    for (int k = 0; k < 10; k++) frame();
    total++;
    if (plat_off !== 10'd0 || plat_state !== 2'd0)
      $display("FAIL after_async: got off %0d state %0d expected 0 0", plat_off, plat_state);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_descend();
`ifdef MAP_CTRL_AUTORETURN_EN
    test_autoreturn();
`else
    test_bottom_terminal();
`endif
    test_restart_priority();
    test_gems();
    test_hold();
    test_en_gate();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
